// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg: shared types, read-during-write mode constants and parity helper for ram_dp_param
package ram_dp_pkg;
   typedef enum logic {INIT, RUN} state_e;
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;
   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_par(input logic [63:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/ram_dp_port_rd.sv
// ram_dp_port_rd: per-port read register with valid strobe, output-enable gating and parity check
// Ports: clk, reset (sync, active-high); rd_i read strobe; op_en_i output enable;
//        data_i/par_i word and stored parity from the array; rdata_o gated read data;
//        rvalid_o one-cycle valid after a read; perr_o parity mismatch, qualified by rvalid_o.
// Parity checking exists only when RAM_DP_PARITY_EN is defined.
module ram_dp_port_rd import ram_dp_pkg::*; #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_i,
   input  logic              op_en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              par_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rvalid_o,
   output logic              perr_o
);
   logic [DATA_W-1:0] data_q, data_d;
   logic              rvalid_q;
   // The read register holds its last word until the next read on this port.
   assign data_d = rd_i ? data_i : data_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         rvalid_q <= rd_i;
      end
   end
`ifdef RAM_DP_PARITY_EN
   logic perr_q, perr_d;
   assign perr_d = rd_i & (even_par(64'(data_i)) != par_i);
   always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else perr_q <= perr_d;
   end
   assign perr_o = perr_q;
`else
   logic unused_par;
   assign unused_par = par_i;
   assign perr_o = 1'b0;
`endif
   assign rdata_o  = op_en_i ? data_q : '0;
   assign rvalid_o = rvalid_q;
endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised true dual-port synchronous RAM with registered reads and clear sweep
// Ports: clk, reset (sync, active-high); per port N in {0,1}: csN select, w_enN write enable,
//        op_enN output enable, addrN, wdataN, rdataN (gated), rvalidN, perrN;
//        collision pulses after a same-address double write; init_busy high during the clear sweep.
// Optional build macro RAM_DP_PARITY_EN adds one stored even-parity bit per word.
module ram_dp_param import ram_dp_pkg::*; #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 4,
   parameter int RDW_MODE   = RDW_OLD,
   parameter int INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs0,
   input  logic              w_en0,
   input  logic              op_en0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   output logic              perr0,
   input  logic              cs1,
   input  logic              w_en1,
   input  logic              op_en1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic              perr1,
   output logic              collision,
   output logic              init_busy
);
   localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_DP_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   logic [MW-1:0]     mem [DEPTH];
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              collision_q, collision_d;
   logic              run, we0, we1, re0, re1, rpar0, rpar1;
   logic [MW-1:0]     wword0, wword1, rword0, rword1;
   assign run = state_q == RUN && !reset;
   assign we0 = run & cs0 & w_en0;
   assign we1 = run & cs1 & w_en1;
   assign re0 = run & cs0 & ~w_en0;
   assign re1 = run & cs1 & ~w_en1;
`ifdef RAM_DP_PARITY_EN
   assign wword0 = {even_par(64'(wdata0)), wdata0};
   assign wword1 = {even_par(64'(wdata1)), wdata1};
   assign rpar0  = rword0[DATA_W];
   assign rpar1  = rword1[DATA_W];
`else
   assign wword0 = wdata0;
   assign wword1 = wdata1;
   assign rpar0  = 1'b0;
   assign rpar1  = 1'b0;
`endif
   // Array reads happen before this edge's writes land, so the non-forwarded path returns old data.
   assign rword0 = (RDW_MODE == RDW_NEW && we1 && addr1 == addr0) ? wword1 : mem[addr0];
   assign rword1 = (RDW_MODE == RDW_NEW && we0 && addr0 == addr1) ? wword0 : mem[addr1];
   assign ptr_d       = state_q == INIT ? ptr_q + 1'b1 : ptr_q;
   assign state_d     = (state_q == INIT && &ptr_q) ? RUN : state_q;
   assign collision_d = we0 & we1 & (addr0 == addr1);
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= (INIT_CLEAR != 0) ? INIT : RUN;
         ptr_q       <= '0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         collision_q <= collision_d;
      end
   end
   // Port 0 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!reset && state_q == INIT) mem[ptr_q] <= '0;
      if (we1) mem[addr1] <= wword1;
      if (we0) mem[addr0] <= wword0;
   end
   ram_dp_port_rd #(.DATA_W(DATA_W)) u_rd0 (
      .clk(clk), .reset(reset), .rd_i(re0), .op_en_i(op_en0),
      .data_i(rword0[DATA_W-1:0]), .par_i(rpar0),
      .rdata_o(rdata0), .rvalid_o(rvalid0), .perr_o(perr0)
   );
   ram_dp_port_rd #(.DATA_W(DATA_W)) u_rd1 (
      .clk(clk), .reset(reset), .rd_i(re1), .op_en_i(op_en1),
      .data_i(rword1[DATA_W-1:0]), .par_i(rpar1),
      .rdata_o(rdata1), .rvalid_o(rvalid1), .perr_o(perr1)
   );
   assign collision = collision_q;
   assign init_busy = state_q == INIT;
endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: directed self-checking bench for ram_dp_param (old-data and forwarding instances)
module tb_ram_dp_param;
   logic        clk = 1'b0;
   logic        reset;
   logic        cs0, w_en0, op_en0, cs1, w_en1, op_en1;
   logic [3:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [15:0] rdata0, rdata1, rdata0_n, rdata1_n;
   logic        rvalid0, rvalid1, perr0, perr1, collision, init_busy;
   logic        rvalid0_n, rvalid1_n, perr0_n, perr1_n, collision_n, init_busy_n;
   int          vecs = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   ram_dp_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .INIT_CLEAR(1)) dut (
      .clk(clk), .reset(reset),
      .cs0(cs0), .w_en0(w_en0), .op_en0(op_en0), .addr0(addr0), .wdata0(wdata0),
      .rdata0(rdata0), .rvalid0(rvalid0), .perr0(perr0),
      .cs1(cs1), .w_en1(w_en1), .op_en1(op_en1), .addr1(addr1), .wdata1(wdata1),
      .rdata1(rdata1), .rvalid1(rvalid1), .perr1(perr1),
      .collision(collision), .init_busy(init_busy)
   );

   ram_dp_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .INIT_CLEAR(1)) dut_fwd (
      .clk(clk), .reset(reset),
      .cs0(cs0), .w_en0(w_en0), .op_en0(op_en0), .addr0(addr0), .wdata0(wdata0),
      .rdata0(rdata0_n), .rvalid0(rvalid0_n), .perr0(perr0_n),
      .cs1(cs1), .w_en1(w_en1), .op_en1(op_en1), .addr1(addr1), .wdata1(wdata1),
      .rdata1(rdata1_n), .rvalid1(rvalid1_n), .perr1(perr1_n),
      .collision(collision_n), .init_busy(init_busy_n)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs0 = 0; w_en0 = 0; op_en0 = 1; addr0 = 0; wdata0 = 0;
      cs1 = 0; w_en1 = 0; op_en1 = 1; addr1 = 0; wdata1 = 0;
   endtask

   task automatic test_reset();
      int n;
      reset = 1; idle();
      cyc(); cyc();
      vecs++; if ({rvalid0, rvalid1, perr0, perr1, collision} !== 5'b0) begin $display("FAIL reset_outs: got %b want 00000", {rvalid0, rvalid1, perr0, perr1, collision}); errs++; end
      vecs++; if (init_busy !== 1'b1) begin $display("FAIL reset_busy: got %b want 1", init_busy); errs++; end
      vecs++; if (rdata0 !== 16'h0) begin $display("FAIL reset_rdata0: got %h want 0000", rdata0); errs++; end
      reset = 0;
      n = 0;
      while (init_busy === 1'b1 && n < 40) begin n++; cyc(); end
      vecs++; if (n !== 16) begin $display("FAIL sweep_len: got %0d want 16", n); errs++; end
      vecs++; if (init_busy_n !== 1'b0) begin $display("FAIL sweep_fwd_done: got %b want 0", init_busy_n); errs++; end
   endtask

   task automatic test_sweep_zero();
      for (int a = 0; a < 16; a++) begin
         cs0 = 1; w_en0 = 0; addr0 = 4'(a);
         cyc();
         vecs++; if (rvalid0 !== 1'b1 || rdata0 !== 16'h0) begin $display("FAIL sweep_rd[%0d]: got v=%b d=%h want v=1 d=0000", a, rvalid0, rdata0); errs++; end
      end
      idle();
      cyc();
      vecs++; if (rvalid0 !== 1'b0) begin $display("FAIL rvalid_drop: got %b want 0", rvalid0); errs++; end
   endtask

   task automatic test_basic_rw();
      cs0 = 1; w_en0 = 1; addr0 = 3; wdata0 = 16'hA5A5;
      cyc();
      vecs++; if (rvalid0 !== 1'b0) begin $display("FAIL wr_no_valid: got %b want 0", rvalid0); errs++; end
      idle(); cs1 = 1; addr1 = 3;
      cyc();
      vecs++; if (rvalid1 !== 1'b1 || rdata1 !== 16'hA5A5 || perr1 !== 1'b0) begin $display("FAIL basic_rd: got v=%b d=%h p=%b want v=1 d=a5a5 p=0", rvalid1, rdata1, perr1); errs++; end
      op_en1 = 0;
      #1;
      vecs++; if (rvalid1 !== 1'b1 || rdata1 !== 16'h0) begin $display("FAIL op_en_gate: got v=%b d=%h want v=1 d=0000", rvalid1, rdata1); errs++; end
      op_en1 = 1; cs1 = 0;
      cyc();
      vecs++; if (rvalid1 !== 1'b0 || rdata1 !== 16'hA5A5) begin $display("FAIL rd_hold: got v=%b d=%h want v=0 d=a5a5", rvalid1, rdata1); errs++; end
      cs0 = 1; w_en0 = 1; addr0 = 4; wdata0 = 16'h1234;
      cs1 = 1; w_en1 = 1; addr1 = 9; wdata1 = 16'h5678;
      cyc();
      vecs++; if (collision !== 1'b0) begin $display("FAIL no_collision: got %b want 0", collision); errs++; end
      w_en0 = 0; w_en1 = 0;
      cyc();
      vecs++; if (rdata0 !== 16'h1234 || rdata1 !== 16'h5678) begin $display("FAIL dual_rd: got %h/%h want 1234/5678", rdata0, rdata1); errs++; end
      idle();
   endtask

   task automatic test_collision();
      cs0 = 1; w_en0 = 1; addr0 = 7; wdata0 = 16'h1111;
      cs1 = 1; w_en1 = 1; addr1 = 7; wdata1 = 16'h2222;
      cyc();
      vecs++; if (collision !== 1'b1) begin $display("FAIL collision_pulse: got %b want 1", collision); errs++; end
      idle(); cs1 = 1; addr1 = 7;
      cyc();
      vecs++; if (collision !== 1'b0) begin $display("FAIL collision_clear: got %b want 0", collision); errs++; end
      vecs++; if (rdata1 !== 16'h1111) begin $display("FAIL collision_win: got %h want 1111", rdata1); errs++; end
      idle();
   endtask

   task automatic test_rdw();
      cs0 = 1; w_en0 = 1; addr0 = 5; wdata0 = 16'h00FF;
      cyc();
      wdata0 = 16'hBEEF; cs1 = 1; w_en1 = 0; addr1 = 5;
      cyc();
      vecs++; if (rdata1 !== 16'h00FF) begin $display("FAIL rdw_old_p1: got %h want 00ff", rdata1); errs++; end
      vecs++; if (rdata1_n !== 16'hBEEF || rvalid1_n !== 1'b1) begin $display("FAIL rdw_new_p1: got v=%b d=%h want v=1 d=beef", rvalid1_n, rdata1_n); errs++; end
      idle(); cs1 = 1; w_en1 = 1; addr1 = 5; wdata1 = 16'hC0DE; cs0 = 1; addr0 = 5;
      cyc();
      vecs++; if (rdata0 !== 16'hBEEF) begin $display("FAIL rdw_old_p0: got %h want beef", rdata0); errs++; end
      vecs++; if (rdata0_n !== 16'hC0DE) begin $display("FAIL rdw_new_p0: got %h want c0de", rdata0_n); errs++; end
      idle(); cs0 = 1; addr0 = 5;
      cyc();
      vecs++; if (rdata0 !== 16'hC0DE) begin $display("FAIL rdw_commit: got %h want c0de", rdata0); errs++; end
      idle();
   endtask

   task automatic test_mid_sweep();
      int n;
      bit seen;
      reset = 1; cyc(); cyc();
      reset = 0;
      repeat (8) cyc();
      vecs++; if (init_busy !== 1'b1) begin $display("FAIL mid_sweep_busy: got %b want 1", init_busy); errs++; end
      reset = 1; cyc();
      reset = 0;
      cs0 = 1; w_en0 = 0; addr0 = 3;
      cs1 = 1; w_en1 = 1; addr1 = 12; wdata1 = 16'hDEAD;
      n = 0; seen = 0;
      while (init_busy === 1'b1 && n < 40) begin
         n++;
         cyc();
         if (rvalid0 || rvalid1) seen = 1;
      end
      idle();
      vecs++; if (n !== 16) begin $display("FAIL restart_len: got %0d want 16", n); errs++; end
      vecs++; if (seen !== 1'b0) begin $display("FAIL sweep_masked_rvalid: got %b want 0", seen); errs++; end
      cs0 = 1; addr0 = 3; cs1 = 1; addr1 = 12;
      cyc();
      vecs++; if (rdata0 !== 16'h0 || rvalid0 !== 1'b1) begin $display("FAIL swept_addr3: got v=%b d=%h want v=1 d=0000", rvalid0, rdata0); errs++; end
      vecs++; if (rdata1 !== 16'h0) begin $display("FAIL masked_write12: got %h want 0000", rdata1); errs++; end
      addr0 = 7; addr1 = 5;
      cyc();
      vecs++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin $display("FAIL swept_7_5: got %h/%h want 0000/0000", rdata0, rdata1); errs++; end
      idle();
      cyc();
   endtask

`ifdef RAM_DP_PARITY_EN
   task automatic test_parity();
      cs0 = 1; w_en0 = 1; addr0 = 2; wdata0 = 16'h0001;
      cyc();
      idle();
      dut.mem[2] = dut.mem[2] ^ 17'h00001;
      cs0 = 1; addr0 = 2;
      cyc();
      vecs++; if (perr0 !== 1'b1 || rvalid0 !== 1'b1) begin $display("FAIL parity_err: got p=%b v=%b want p=1 v=1", perr0, rvalid0); errs++; end
      vecs++; if (perr0_n !== 1'b0) begin $display("FAIL parity_clean_inst: got %b want 0", perr0_n); errs++; end
      w_en0 = 1; wdata0 = 16'h0001;
      cyc();
      w_en0 = 0;
      cyc();
      vecs++; if (perr0 !== 1'b0 || rvalid0 !== 1'b1 || rdata0 !== 16'h0001) begin $display("FAIL parity_ok: got p=%b v=%b d=%h want p=0 v=1 d=0001", perr0, rvalid0, rdata0); errs++; end
      idle();
      cyc();
   endtask
`endif

   initial begin
      test_reset();
      test_sweep_zero();
      test_basic_rw();
      test_collision();
      test_rdw();
      test_mid_sweep();
`ifdef RAM_DP_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
